// File: rtl/axi4stream_packet_packer.sv
// Packs narrow AXI4-Stream beats into wide words with a registered valid/ready output stage.
// Optional AXIS_PACKER_STATS_EN adds pkt_count / short_count statistics outputs.
module axi4stream_packet_packer #(
  parameter  int AXI_WIDTH    = 8,
  parameter  int BUFFER_WIDTH = 64,
  localparam int BEATS        = (BUFFER_WIDTH + AXI_WIDTH - 1) / AXI_WIDTH,
  localparam int CNT_W        = $clog2(BEATS + 1)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [AXI_WIDTH-1:0]    tdata,
  input  logic                    tvalid,
  input  logic                    tlast,
  output logic                    tready,
  output logic [BUFFER_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [CNT_W-1:0]        out_beats
`ifdef AXIS_PACKER_STATS_EN
  ,
  output logic [31:0]             pkt_count,
  output logic [31:0]             short_count
`endif
);

  // Slots are laid out over a whole number of beats; the top slot is truncated on output.
  localparam int PAD_W = BEATS * AXI_WIDTH;

  logic [PAD_W-1:0]        acc_q, acc_d;
  logic [PAD_W-1:0]        word_merged;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BUFFER_WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [CNT_W-1:0]        out_beats_q, out_beats_d;
  logic                    accept;
  logic                    closing;

  assign tready  = !out_valid_q || out_ready;
  assign accept  = tvalid && tready;
  assign closing = (cnt_q == CNT_W'(BEATS - 1)) || tlast;

  // Current beat lands in slot cnt; lower slots keep acc, higher slots are forced to zero.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
      localparam logic [CNT_W-1:0] SLOT = CNT_W'(gi);
      assign word_merged[gi*AXI_WIDTH +: AXI_WIDTH] =
        (SLOT < cnt_q)  ? acc_q[gi*AXI_WIDTH +: AXI_WIDTH] :
        (SLOT == cnt_q) ? tdata : '0;
    end
  endgenerate

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_beats_d = out_beats_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (closing) begin
        out_data_d  = word_merged[BUFFER_WIDTH-1:0];
        out_valid_d = 1'b1;
        out_last_d  = tlast;
        out_beats_d = cnt_q + CNT_W'(1);
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = word_merged;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_beats_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_beats = out_beats_q;

`ifdef AXIS_PACKER_STATS_EN
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [31:0] short_count_q, short_count_d;

  // Counted on the output handshake, so words dropped by reset never count.
  always_comb begin
    pkt_count_d   = pkt_count_q;
    short_count_d = short_count_q;
    if (out_valid_q && out_ready) begin
      if (out_last_q) begin
        pkt_count_d = pkt_count_q + 32'd1;
      end
      if (out_beats_q < CNT_W'(BEATS)) begin
        short_count_d = short_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      pkt_count_q   <= '0;
      short_count_q <= '0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      short_count_q <= short_count_d;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign short_count = short_count_q;
`endif

endmodule

// File: tb/tb_axi4stream_packet_packer.sv
// Scoreboard bench for axi4stream_packet_packer (8-bit beats into 32-bit words).
module tb_axi4stream_packet_packer;
  localparam int AW    = 8;
  localparam int BW    = 32;
  localparam int BEATS = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          areset;
  logic [AW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [CW-1:0] out_beats;
`ifdef AXIS_PACKER_STATS_EN
  logic [31:0]   pkt_count;
  logic [31:0]   short_count;
`endif

  always #5 clk = ~clk;

  axi4stream_packet_packer #(.AXI_WIDTH(AW), .BUFFER_WIDTH(BW)) dut (
    .aclk      (clk),
    .areset    (areset),
    .tdata     (tdata),
    .tvalid    (tvalid),
    .tlast     (tlast),
    .tready    (tready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_beats (out_beats)
`ifdef AXIS_PACKER_STATS_EN
    ,
    .pkt_count   (pkt_count),
    .short_count (short_count)
`endif
  );

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
    logic [CW-1:0] beats;
  } word_t;

  word_t         exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            exp_pkt = 0;
  int            exp_short = 0;
  int            stall_left = 0;
  bit            rand_mode = 1'b0;
  bit            hold_prev = 1'b0;
  logic [BW-1:0] held_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    word_t w;
    if (!areset) begin
      hold_prev = 1'b0;
      exp_pkt   = 0;
      exp_short = 0;
    end else begin
      if (hold_prev) check("hold_stable", out_data, held_data);
      if (out_valid && !out_ready) check("bp_tready", tready, 1'b0);
      else                         check("tready", tready, 1'b1);
      hold_prev = out_valid && !out_ready;
      held_data = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_word", out_data, 64'hDEAD_0000);
        end else begin
          w = exp_q.pop_front();
          $display("word data=%08h last=%0b beats=%0d", out_data, out_last, out_beats);
          check("out_data", out_data, w.data);
          check("out_last", out_last, w.last);
          check("out_beats", out_beats, w.beats);
          if (w.last) exp_pkt++;
          if (int'(w.beats) < BEATS) exp_short++;
        end
      end
    end
  end

  // Model: expected words built purely from packet contents.
  task automatic push_words(input logic [7:0] pkt[$]);
    word_t w;
    int    n = 0;
    w.data = '0;
    foreach (pkt[i]) begin
      w.data[n*AW +: AW] = pkt[i];
      n++;
      if (n == BEATS || i == pkt.size() - 1) begin
        w.last  = (i == pkt.size() - 1);
        w.beats = CW'(n);
        exp_q.push_back(w);
        w.data = '0;
        n = 0;
      end
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
  task automatic send_beat(input logic [7:0] d, input logic l);
    bit ok = 1'b0;
    if (rand_mode && stall_left == 0) out_ready = 1'($urandom_range(0, 1));
    tdata  = d;
    tvalid = 1'b1;
    tlast  = l;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) out_ready = 1'b1;
      end else if (rand_mode) begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!ok) check("tready_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_packet(input logic [7:0] pkt[$], input bit with_last);
    if (with_last) push_words(pkt);
    foreach (pkt[i]) send_beat(pkt[i], with_last && (i == pkt.size() - 1));
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic drain();
    rand_mode = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_beats"}, out_beats, 0);
    check({tag, "_tready"}, tready, 1);
`ifdef AXIS_PACKER_STATS_EN
    check({tag, "_pkt_count"}, pkt_count, 0);
    check({tag, "_short_count"}, short_count, 0);
`endif
  endtask

  initial begin
    logic [7:0] pkt[$];
    int         t0;
    areset    = 1'b0;
    tdata     = '0;
    tvalid    = 1'b0;
    tlast     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst0");
    @(posedge clk);
    #1;
    areset = 1'b1;
    @(posedge clk);
    #1;

    // Full word with latency check on the closing beat.
    pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    push_words(pkt);
    for (int i = 0; i < 3; i++) send_beat(pkt[i], 1'b0);
    check("lat_pre", out_valid, 1'b0);
    send_beat(pkt[3], 1'b1);
    check("lat_post", out_valid, 1'b1);
    tvalid = 1'b0;
    tlast  = 1'b0;
    drain();

    repeat (10) @(posedge clk);
    #1;
    pkt = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_packet(pkt, 1'b1);
    drain();

    // Two words back-to-back at one beat per cycle.
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    t0 = cyc;
    send_packet(pkt, 1'b1);
    check("throughput_cycles", cyc - t0, 8);
    drain();

    // Backpressure: stall 5 cycles once the first word is waiting.
    pkt = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    push_words(pkt);
    foreach (pkt[i]) begin
      if (i == 4) begin
        out_ready  = 1'b0;
        stall_left = 5;
      end
      send_beat(pkt[i], i == pkt.size() - 1);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    drain();

    // Short words and single-beat packets.
    pkt = '{8'h11, 8'h22, 8'h33};
    send_packet(pkt, 1'b1);
    pkt = '{8'h5A};
    send_packet(pkt, 1'b1);
    pkt = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    send_packet(pkt, 1'b1);
    drain();

    // Reset mid-word discards the partial word.
    pkt = '{8'h21, 8'h43, 8'h65};
    send_packet(pkt, 1'b0);
    areset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("rst_mid");
    end
    @(posedge clk);
    #1;
    areset = 1'b1;
    pkt = '{8'h87, 8'hA9, 8'hCB, 8'hED};
    send_packet(pkt, 1'b1);
    drain();

    // Random packets under random backpressure.
    rand_mode = 1'b1;
    for (int p = 0; p < 20; p++) begin
      pkt.delete();
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) pkt.push_back(8'($urandom));
      send_packet(pkt, 1'b1);
    end
    drain();

`ifdef AXIS_PACKER_STATS_EN
    check("pkt_count", pkt_count, exp_pkt);
    check("short_count", short_count, exp_short);
`endif
    check("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi4stream_packet_packer.md
# axi4stream_packet_packer

Parametrised AXI4-Stream slave that packs narrow input beats into wide output words, with a registered output handshake instead of a free-running valid strobe. Each word closes when it is full or when the input packet ends (`tlast`). A short final segment is zero-padded and tagged with its beat count. The block sits behind the HDMI input path and feeds wide pixel words to the upscaler core at full input throughput under backpressure.

## Interface
- `AXI_WIDTH`, 8: input beat width in bits.
- `BUFFER_WIDTH`, 64: output word width in bits; must be ≥ `AXI_WIDTH`.
- `BEATS` (derived localparam): ceil(`BUFFER_WIDTH`/`AXI_WIDTH`), beats per word.
- `CNT_W` (derived localparam): clog2(`BEATS`+1).

Ports (one clock; reset is asynchronous and active-low):
- `aclk`  in  1  clock; all logic on rising edge.
- `areset`  in  1  asynchronous, active-low reset.
- `tdata`  in  `AXI_WIDTH`  input beat.
- `tvalid`  in  1  input beat valid.
- `tlast`  in  1  final beat of packet.
- `tready`  out  1  block can accept a beat.
- `out_data`  out  `BUFFER_WIDTH`  packed word.
- `out_valid`  out  1  `out_data` holds an unaccepted word.
- `out_ready`  in  1  downstream accepts the word.
- `out_last`  out  1  word closed by `tlast`.
- `out_beats`  out  `CNT_W`  number of beats in the word, 1..`BEATS`.

## Operation
- Accept condition: `tvalid && tready`.
- Registers:
  - accumulator `acc` (`BUFFER_WIDTH`);
  - slot counter `cnt` (0..`BEATS`-1);
  - output register (`out_data`, `out_valid`, `out_last`, `out_beats`).
- Beat placement:
  - first beat of a word goes to bits [`AXI_WIDTH`-1:0];
  - beat k goes to slot k (little-endian: first beat is least significant).
- If `BUFFER_WIDTH` is not a multiple of `AXI_WIDTH`, the upper bits of the last slot are truncated.
- Accepted non-closing beat (`cnt` < `BEATS`-1 and `tlast`=0): write the slot in `acc`, increment `cnt`.
- Accepted closing beat (`cnt` = `BEATS`-1, or `tlast`=1):
  - load the output register with `acc` merged with this beat;
  - zero all slots above `cnt`;
  - set `out_valid`=1, `out_last`=`tlast`, `out_beats`=`cnt`+1;
  - clear `acc` to 0 and `cnt` to 0.
- `tlast` on a beat in the last slot: the word is full and `out_last`=1.
- Packets longer than `BEATS` produce several words; only the final one has `out_last`=1.
- `tready` = !`out_valid` || `out_ready` (combinational from `out_ready`).
- While `tready`=0, `tdata`/`tvalid`/`tlast` are ignored. Upstream must hold them per AXI4-Stream, and the bench checks that nothing is lost.
- `out_valid` clears on `out_valid && out_ready` unless a new closing beat is accepted in the same cycle. In that case the output register reloads and `out_valid` stays 1 (back-to-back).
- Output fields are stable while `out_valid && !out_ready`.

## Timing
- Reset values (async assert, sync deassert expected upstream):
  - `acc`=0, `cnt`=0;
  - `out_data`=0, `out_valid`=0, `out_last`=0, `out_beats`=0;
  - `tready` reads 1.
- Latency: word appears on `out_valid` the cycle after its closing beat is accepted.
- Throughput: one beat per cycle sustained while `out_ready`=1; no bubble between words.
- Backpressure: with `out_valid`=1 and `out_ready`=0, `tready`=0 the same cycle. Resumes the cycle `out_ready` rises.
- Reset mid-word or mid-hold discards the partial word and the pending output word; no output follows.
- `tvalid` dropping mid-word: `acc`/`cnt` hold indefinitely; there is no timeout.

## Configuration
- `AXIS_PACKER_STATS_EN` defined adds two outputs:
  - `pkt_count` [31:0]: increments on each accepted output word with `out_last`=1;
  - `short_count` [31:0]: increments on each accepted word with `out_beats` < `BEATS`.
  - Both reset to 0 and wrap at 2^32.
- Without the macro these ports and their registers do not exist; all other behaviour is identical.

## Test plan
- AXI_WIDTH=8, BUFFER_WIDTH=32, `out_ready`=1; send AA,BB,CC,DD with `tlast` on DD -> one word 0xDDCCBBAA, `out_last`=1, `out_beats`=4, `out_valid` one cycle after DD accepted.
- BUFFER_WIDTH=64; send AA,BB,CC,DD (`tlast` on DD), idle 10 cycles, then EF,BE,AD,DE (`tlast`) -> words 0x00000000DDCCBBAA then 0x00000000DEADBEEF, each `out_beats`=4, `out_last`=1.
- BUFFER_WIDTH=32; 8 consecutive beats 0x01..0x08 with `tlast` on 0x08 -> 0x04030201 (`out_last`=0) then 0x08070605 (`out_last`=1) back-to-back with no bubble.
- Hold `out_ready`=0 after the first word while the source keeps `tvalid`=1 -> `tready`=0 the same cycle, `out_data` stable. Release after 5 cycles -> no beat lost or duplicated.
- Send 21,43,65 (no `tlast`), assert `areset` low for 2 cycles, then send 87,A9,CB,ED with `tlast` -> only 0xEDCBA987 output; all outputs 0 during reset.
- With `AXIS_PACKER_STATS_EN`, BUFFER_WIDTH=64; run the above packets -> `pkt_count` and `short_count` match the accepted words, 0 after reset.
